// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: shares one single-port pixel SRAM between raster-order display prefetch and a pixel writer.
// Define VGA_FB_UNDERFLOW_STATS_EN to add the saturating underflow_cnt output.
module vga_fb_scheduler #(
    parameter int AW         = 19,
    parameter int DW         = 30,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4,
    parameter int FRAME_PIX  = 480000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          pix_pop,
    output logic [DW-1:0] pix_data,
    output logic          underflow,
`ifdef VGA_FB_UNDERFLOW_STATS_EN
    output logic [15:0]   underflow_cnt,
`endif
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] DEPTH_L   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LOW_L     = CW'(LOW_WM);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_WR} slot_e;

    logic [DW-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, level;
    logic          rd_v1_q, rd_v1_d, rd_v2_q, rd_v2_d;
    logic [AW-1:0] fetch_q, fetch_d, fetch_cur;
    logic          done_q, done_d, done_cur;
    logic          underflow_q, underflow_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d, wr_ack_q, wr_ack_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          empty, push, pop_ok;
    slot_e         slot;

    // rd_v1: read visible on the memory port now; rd_v2: its data is on mem_rdata now.
    // Level counts both so the FIFO can never be over-subscribed.
    always_comb begin
        empty       = count_q == '0;
        pix_data    = empty ? '0 : fifo_q[rd_ptr_q];
        push        = rd_v2_q && !frame_start;
        pop_ok      = pix_pop && !empty && !frame_start;
        level       = frame_start ? '0 : count_q + CW'(rd_v1_q) + CW'(rd_v2_q);
        fetch_cur   = frame_start ? '0 : fetch_q;
        done_cur    = frame_start ? 1'b0 : done_q;
        slot        = (!done_cur && level < LOW_L)   ? SLOT_DISP :
                      (wr_req && !wr_ack_q)          ? SLOT_WR   :
                      (!done_cur && level < DEPTH_L) ? SLOT_DISP : SLOT_IDLE;
        fetch_d     = (slot == SLOT_DISP) ? fetch_cur + AW'(1) : fetch_cur;
        done_d      = done_cur || (slot == SLOT_DISP && fetch_cur == LAST_ADDR);
        rd_v1_d     = slot == SLOT_DISP;
        rd_v2_d     = rd_v1_q && !frame_start;
        wr_ptr_d    = frame_start ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d    = frame_start ? '0 : rd_ptr_q + PW'(pop_ok);
        count_d     = frame_start ? '0 : count_q + CW'(push) - CW'(pop_ok);
        underflow_d = !frame_start && (underflow_q || (pix_pop && empty));
        mem_en_d    = slot != SLOT_IDLE;
        mem_we_d    = slot == SLOT_WR;
        wr_ack_d    = slot == SLOT_WR;
        mem_addr_d  = (slot == SLOT_DISP) ? fetch_cur : (slot == SLOT_WR) ? wr_addr : mem_addr_q;
        mem_wdata_d = (slot == SLOT_WR) ? wr_data : mem_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rd_v1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
            fetch_q     <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rd_v1_q     <= rd_v1_d;
            rd_v2_q     <= rd_v2_d;
            fetch_q     <= fetch_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            wr_ack_q    <= wr_ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rdata;
    end

`ifdef VGA_FB_UNDERFLOW_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;
    always_comb begin
        ucnt_d = frame_start ? '0 : (pix_pop && empty && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ucnt_q <= '0;
        else        ucnt_q <= ucnt_d;
    end
    assign underflow_cnt = ucnt_q;
`endif

    assign underflow = underflow_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign wr_ack    = wr_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule
